cpu_rfwrite_stage: RTL and testbench

//  Final (register-file write) stage of the 4-stage CPU pipeline, i.e. the producer side of the execute-stage bypass.

---
 rtl/cpu_rfwrite_stage_if.sv | 37 +++
 rtl/cpu_rfwrite_stage.sv | 163 ++++++++++++++++
 tb/tb_cpu_rfwrite_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_rfwrite_stage_if.sv
// cpu_rfwrite_stage_if
//   Bundles the execute-side inputs, load read-data handshake and the RF
//   write / bypass outputs of the register-file write stage.
//   master : execute/memory side (drives x_*, mem_*)
//   slave  : the write stage itself (drives x_ready, w_*, rf_*, fwd_data,
//            stall, ld_err)
interface cpu_rfwrite_stage_if;
    logic        x_valid;
    logic [15:0] x_instr;
    logic [15:0] x_pc;
    logic [15:0] x_alu;
    logic [15:0] x_opnd;
    logic [15:0] x_rx;
    logic        x_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        w_valid;
    logic [15:0] w_instr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] fwd_data;
    logic        stall;
    logic        ld_err;

    modport master (
        output x_valid, x_instr, x_pc, x_alu, x_opnd, x_rx, mem_rvalid, mem_rdata,
        input  x_ready, w_valid, w_instr, rf_we, rf_waddr, rf_wdata, fwd_data,
               stall, ld_err
    );

    modport slave (
        input  x_valid, x_instr, x_pc, x_alu, x_opnd, x_rx, mem_rvalid, mem_rdata,
        output x_ready, w_valid, w_instr, rf_we, rf_waddr, rf_wdata, fwd_data,
               stall, ld_err
    );
endinterface

// File: rtl/cpu_rfwrite_stage.sv
// cpu_rfwrite_stage
//   Last pipeline stage: registers the instruction retiring from execute,
//   drives the single register-file write port and the identical bypass value
//   back to execute, and holds the pipe while a load waits for read data.
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : cpu_rfwrite_stage_if.slave (x_* capture, mem_* load data,
//              x_ready/stall, w_valid/w_instr, rf_we/rf_waddr/rf_wdata,
//              fwd_data, ld_err)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; a load without data in its first cycle stalls
// WAIT_LD  | load pending; stall until mem_rvalid or timeout (ld_err)
module cpu_rfwrite_stage #(
    parameter logic [15:0] NOP_INSTR  = 16'h0007,
    parameter int          LD_TIMEOUT = 255,
    parameter int          CW         = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    cpu_rfwrite_stage_if.slave  bus
);
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_WAIT_LD = 1'b1;

    localparam logic [3:0] OP_MV    = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_LD    = 4'd4;
    localparam logic [3:0] OP_MVHI  = 4'd6;
    localparam logic [3:0] OP_CALLR = 4'd12;

    logic [0:0]    state, state_nxt;
    logic [CW-1:0] ld_cnt, ld_cnt_nxt;
    logic [15:0]   w_instr;
    logic          w_valid;
    logic [15:0]   pc_q, alu_q, opnd_q;
    logic [7:0]    rx_q;

    logic          stall, ld_err, ld_we;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [15:0]   rf_wdata;

    logic [3:0]    op;
    logic          imm_sel;
    logic [7:0]    imm8;

    assign op      = w_instr[3:0];
    assign imm_sel = w_instr[4];
    assign imm8    = w_instr[15:8];

    // Load timer counts down from LD_TIMEOUT-1 on entry so that the terminal
    // count (zero) lands on the LD_TIMEOUT-th WAIT_LD cycle.
    always_comb begin
        state_nxt  = state;
        ld_cnt_nxt = ld_cnt;
        stall      = 1'b0;
        ld_err     = 1'b0;
        ld_we      = 1'b0;
        case (state)
            ST_RUN: begin
                if (w_valid && op == OP_LD) begin
                    if (bus.mem_rvalid) begin
                        ld_we = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_nxt  = ST_WAIT_LD;
                        ld_cnt_nxt = CW'(LD_TIMEOUT - 1);
                    end
                end
            end
            ST_WAIT_LD: begin
                if (bus.mem_rvalid) begin
                    ld_we      = 1'b1;
                    state_nxt  = ST_RUN;
                    ld_cnt_nxt = '0;
                end else if (ld_cnt == '0) begin
                    ld_err     = 1'b1;
                    state_nxt  = ST_RUN;
                end else begin
                    stall      = 1'b1;
                    ld_cnt_nxt = ld_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_RUN;
                ld_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 3'd0;
        rf_wdata = 16'd0;
        if (w_valid) begin
            rf_waddr = w_instr[7:5];
            case (op)
                OP_MV: begin
                    rf_we    = 1'b1;
                    rf_wdata = imm_sel ? {{8{imm8[7]}}, imm8} : opnd_q;
                end
                OP_ADD, OP_SUB: begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_q;
                end
                OP_LD: begin
                    rf_we    = ld_we;
                    rf_wdata = ld_we ? bus.mem_rdata : 16'd0;
                end
                OP_MVHI: begin
                    rf_we    = 1'b1;
                    rf_wdata = {imm8, rx_q};
                end
                OP_CALLR: begin
                    rf_we    = 1'b1;
                    rf_waddr = 3'd7;
                    rf_wdata = pc_q;
                end
                default: begin
                    rf_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            ld_cnt  <= '0;
            w_instr <= NOP_INSTR;
            w_valid <= 1'b0;
            pc_q    <= 16'd0;
            alu_q   <= 16'd0;
            opnd_q  <= 16'd0;
            rx_q    <= 8'd0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= ld_cnt_nxt;
            if (!stall) begin
                w_instr <= bus.x_valid ? bus.x_instr : NOP_INSTR;
                w_valid <= bus.x_valid;
                pc_q    <= bus.x_pc;
                alu_q   <= bus.x_alu;
                opnd_q  <= bus.x_opnd;
                rx_q    <= bus.x_rx[7:0];
            end
        end
    end

    assign bus.x_ready  = !stall;
    assign bus.stall    = stall;
    assign bus.ld_err   = ld_err;
    assign bus.w_valid  = w_valid;
    assign bus.w_instr  = w_instr;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.fwd_data = rf_wdata;
endmodule

// File: tb/tb_cpu_rfwrite_stage.sv
module tb_cpu_rfwrite_stage;
    logic clk;
    logic reset_n;

    cpu_rfwrite_stage_if bus ();

    cpu_rfwrite_stage #(
        .NOP_INSTR (16'h0007),
        .LD_TIMEOUT(4),
        .CW        (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected writes: {addr, data}
    logic [18:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && bus.rf_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected at %0t",
                         bus.rf_waddr, bus.rf_wdata, $time);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e[18:16] || bus.rf_wdata !== e[15:0] ||
                    bus.fwd_data !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL rf_write: addr %0d data %h fwd %h expected addr %0d data %h at %0t",
                             bus.rf_waddr, bus.rf_wdata, bus.fwd_data, e[18:16], e[15:0], $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic present(input logic [15:0] ins, input logic [15:0] pc,
                           input logic [15:0] alu, input logic [15:0] opnd,
                           input logic [15:0] rx);
        bus.x_valid = 1'b1;
        bus.x_instr = ins;
        bus.x_pc    = pc;
        bus.x_alu   = alu;
        bus.x_opnd  = opnd;
        bus.x_rx    = rx;
    endtask

    task automatic bubble();
        bus.x_valid = 1'b0;
        bus.x_instr = 16'hFFFF;
    endtask

    // Issue one instruction (captured at the next edge) and record its write.
    task automatic send(input logic [15:0] ins, input logic [15:0] pc,
                        input logic [15:0] alu, input logic [15:0] opnd,
                        input logic [15:0] rx, input logic we,
                        input logic [2:0] addr, input logic [15:0] data);
        present(ins, pc, alu, opnd, rx);
        if (we) exp_q.push_back({addr, data});
        step();
        bubble();
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.x_valid    = 1'b0;
        bus.x_instr    = 16'h0000;
        bus.x_pc       = 16'h0000;
        bus.x_alu      = 16'h0000;
        bus.x_opnd     = 16'h0000;
        bus.x_rx       = 16'h0000;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        #12;
        chk("rst_w_instr", bus.w_instr, 16'h0007);
        chk("rst_w_valid", {15'd0, bus.w_valid}, 16'd0);
        chk("rst_rf_we",   {15'd0, bus.rf_we}, 16'd0);
        chk("rst_x_ready", {15'd0, bus.x_ready}, 16'd1);
        chk("rst_stall",   {15'd0, bus.stall}, 16'd0);
        chk("rst_wdata",   bus.rf_wdata, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // add R3 <= 1234
        send(16'h0061, 16'h0, 16'h1234, 16'h0, 16'h0, 1'b1, 3'd3, 16'h1234);
        sample();
        chk("add_w_instr", bus.w_instr, 16'h0061);
        chk("add_w_valid", {15'd0, bus.w_valid}, 16'd1);
        step();

        // ld R2 with 3 stall cycles; mv R5 waits behind it
        send(16'h0044, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        present(16'h00A0, 16'h0, 16'h0, 16'h5555, 16'h0);
        sample();
        chk("ld_stall_c1", {15'd0, bus.stall}, 16'd1);
        chk("ld_xready_c1", {15'd0, bus.x_ready}, 16'd0);
        step(); sample();
        chk("ld_stall_c2", {15'd0, bus.stall}, 16'd1);
        chk("ld_hold_instr", bus.w_instr, 16'h0044);
        step(); sample();
        chk("ld_stall_c3", {15'd0, bus.stall}, 16'd1);
        #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hBEEF;
        exp_q.push_back({3'd2, 16'hBEEF});
        exp_q.push_back({3'd5, 16'h5555});
        #1;
        chk("ld_stall_data", {15'd0, bus.stall}, 16'd0);
        chk("ld_we_data", {15'd0, bus.rf_we}, 16'd1);
        step();
        bus.mem_rvalid = 1'b0;
        bubble();
        sample();
        chk("ld_next_capt", bus.w_instr, 16'h00A0);
        step();

        // ld R1 timeout (LD_TIMEOUT=4)
        send(16'h0024, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        sample();
        chk("to_stall_run", {15'd0, bus.stall}, 16'd1);
        for (int i = 1; i <= 3; i++) begin
            step(); sample();
            chk("to_stall_wait", {15'd0, bus.stall}, 16'd1);
            chk("to_no_err",     {15'd0, bus.ld_err}, 16'd0);
        end
        step(); sample();
        chk("to_ld_err",   {15'd0, bus.ld_err}, 16'd1);
        chk("to_stall_0",  {15'd0, bus.stall}, 16'd0);
        chk("to_no_write", {15'd0, bus.rf_we}, 16'd0);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h9999;
        sample();
        chk("to_err_pulse", {15'd0, bus.ld_err}, 16'd0);
        chk("to_run_instr", bus.w_instr, 16'h0007);
        step();
        bus.mem_rvalid = 1'b0;

        // callr and mvhi
        send(16'h000C, 16'h0042, 16'h0, 16'h0, 16'h0, 1'b1, 3'd7, 16'h0042);
        send(16'hAB86, 16'h0, 16'h0, 16'h0, 16'h00CD, 1'b1, 3'd4, 16'hABCD);
        // cmp, st, bubble produce no write; mvi sign-extends; sub wraps
        send(16'h0023, 16'h0, 16'h7777, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        sample();
        chk("cmp_no_we", {15'd0, bus.rf_we}, 16'd0);
        send(16'h0065, 16'h0, 16'h7777, 16'h8888, 16'h0, 1'b0, 3'd0, 16'h0);
        sample();
        chk("st_no_we", {15'd0, bus.rf_we}, 16'd0);
        step(); sample();
        chk("bubble_no_we", {15'd0, bus.rf_we}, 16'd0);
        chk("bubble_w_valid", {15'd0, bus.w_valid}, 16'd0);
        send(16'hF0D0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd6, 16'hFFF0);
        send(16'h0022, 16'h0, 16'hFFFF, 16'h0, 16'h0, 1'b1, 3'd1, 16'hFFFF);

        // back-to-back loads with data in the same cycle
        send(16'h0064, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1111;
        exp_q.push_back({3'd3, 16'h1111});
        present(16'h00A4, 16'h0, 16'h0, 16'h0, 16'h0);
        sample();
        chk("ld2_no_stall", {15'd0, bus.stall}, 16'd0);
        step();
        bus.mem_rdata = 16'h2222;
        exp_q.push_back({3'd5, 16'h2222});
        bubble();
        sample();
        chk("ld2_capt", bus.w_instr, 16'h00A4);
        step();
        bus.mem_rvalid = 1'b0;

        // reset mid-WAIT_LD
        send(16'h00E4, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        step();
        sample();
        chk("pre_rst_stall", {15'd0, bus.stall}, 16'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_w_instr", bus.w_instr, 16'h0007);
        chk("arst_rf_we",   {15'd0, bus.rf_we}, 16'd0);
        chk("arst_stall",   {15'd0, bus.stall}, 16'd0);
        chk("arst_x_ready", {15'd0, bus.x_ready}, 16'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hDEAD;
        @(negedge clk);
        reset_n = 1'b1;
        step(); step();
        bus.mem_rvalid = 1'b0;
        step(); step();

        chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
